// File: rtl/voice_allocator.sv
// Polyphonic voice allocator: free-voice-first allocation with oldest-voice stealing,
// plus a forced gate-low gap on steal/retrigger so each envelope sees a fresh rising edge.
module voice_allocator #(
   parameter int NUM_VOICES = 4,
   parameter int STEAL_GAP  = 2
) (
   input  logic                    clk_i,
   input  logic                    rst_ni,
   input  logic                    event_valid_i,
   output logic                    event_ready_o,
   input  logic                    event_on_i,
   input  logic [6:0]              event_note_i,
   input  logic                    all_off_i,
   output logic [7*NUM_VOICES-1:0] voice_note_o,
   output logic [NUM_VOICES-1:0]   voice_gate_o,
   output logic                    steal_pulse_o
);

   localparam int RW = $clog2(NUM_VOICES);
   typedef logic [RW-1:0] idx_t;

   typedef enum logic [1:0] {S_IDLE, S_DECIDE, S_GAP, S_COMMIT} state_t;

   typedef struct packed {
      logic       on;
      logic [6:0] note;
   } evt_t;

   state_t                          state_q, state_d;
   evt_t                            evt_q, evt_d;
   idx_t                            tgt_q, tgt_d;
   logic [3:0]                      cnt_q, cnt_d;
   logic [NUM_VOICES-1:0]           gate_q, gate_d;
   logic [NUM_VOICES-1:0][6:0]      note_q, note_d;
   logic [NUM_VOICES-1:0][RW-1:0]   rank_q, rank_d;
   logic                            ready_q, ready_d;
   logic                            steal_q, steal_d;

   // Voice lookup against the latched event
   logic                  match_any, free_any;
   idx_t                  match_idx, free_idx, oldest_idx, free_rank;
   logic [NUM_VOICES-1:0] off_mask;

   always_comb begin
      match_any  = 1'b0;
      match_idx  = '0;
      free_any   = 1'b0;
      free_idx   = '0;
      free_rank  = '0;
      oldest_idx = '0;
      off_mask   = '0;
      for (int i = 0; i < NUM_VOICES; i++) begin
         if (gate_q[i] && (note_q[i] == evt_q.note)) begin
            off_mask[i] = 1'b1;
            if (!match_any) begin
               match_any = 1'b1;
               match_idx = idx_t'(i);
            end
         end
         if (!gate_q[i] && (!free_any || (rank_q[i] < free_rank))) begin
            free_any  = 1'b1;
            free_idx  = idx_t'(i);
            free_rank = rank_q[i];
         end
         if (rank_q[i] == '0) oldest_idx = idx_t'(i);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= S_IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      evt_d   = evt_q;
      tgt_d   = tgt_q;
      cnt_d   = cnt_q;
      if (all_off_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (event_valid_i && ready_q) begin
                  evt_d   = '{on: event_on_i, note: event_note_i};
                  state_d = S_DECIDE;
               end
            end
            S_DECIDE: begin
               if (!evt_q.on) begin
                  state_d = S_IDLE;
               end else if (match_any) begin
                  tgt_d   = match_idx;
                  cnt_d   = 4'(STEAL_GAP - 1);
                  state_d = S_GAP;
               end else if (free_any) begin
                  tgt_d   = free_idx;
                  state_d = S_COMMIT;
               end else begin
                  tgt_d   = oldest_idx;
                  cnt_d   = 4'(STEAL_GAP - 1);
                  state_d = S_GAP;
               end
            end
            S_GAP: begin
               if (cnt_q == '0) state_d = S_COMMIT;
               else             cnt_d   = cnt_q - 4'd1;
            end
            S_COMMIT: state_d = S_IDLE;
            default:  state_d = S_IDLE;
         endcase
      end
   end

   always_comb begin
      gate_d  = gate_q;
      note_d  = note_q;
      rank_d  = rank_q;
      steal_d = 1'b0;
      ready_d = (state_d == S_IDLE);
      if (all_off_i) begin
         gate_d = '0;
      end else begin
         case (state_q)
            S_DECIDE: begin
               if (!evt_q.on) begin
                  gate_d = gate_q & ~off_mask;
               end else if (match_any) begin
                  gate_d[match_idx] = 1'b0;
               end else if (!free_any) begin
                  gate_d[oldest_idx] = 1'b0;
                  steal_d            = 1'b1;
               end
            end
            S_COMMIT: begin
               note_d[tgt_q] = evt_q.note;
               gate_d[tgt_q] = 1'b1;
               // Target becomes most recent; everything above its old slot shifts down
               for (int i = 0; i < NUM_VOICES; i++) begin
                  if (idx_t'(i) == tgt_q)           rank_d[i] = idx_t'(NUM_VOICES - 1);
                  else if (rank_q[i] > rank_q[tgt_q]) rank_d[i] = rank_q[i] - idx_t'(1);
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         evt_q   <= '0;
         tgt_q   <= '0;
         cnt_q   <= '0;
         gate_q  <= '0;
         note_q  <= '0;
         ready_q <= 1'b0;
         steal_q <= 1'b0;
         for (int i = 0; i < NUM_VOICES; i++) rank_q[i] <= idx_t'(i);
      end else begin
         evt_q   <= evt_d;
         tgt_q   <= tgt_d;
         cnt_q   <= cnt_d;
         gate_q  <= gate_d;
         note_q  <= note_d;
         rank_q  <= rank_d;
         ready_q <= ready_d;
         steal_q <= steal_d;
      end
   end

   assign event_ready_o = ready_q;
   assign voice_note_o  = note_q;
   assign voice_gate_o  = gate_q;
   assign steal_pulse_o = steal_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed test-plan scenarios plus random events checked
// against an LRU-list model of allocation and event latency.
module tb_voice_allocator;

   localparam int NV   = 4;
   localparam int SG   = 2;
   localparam int MAXK = 6;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            ev_valid = 1'b0;
   logic            ev_on = 1'b0;
   logic [6:0]      ev_note = '0;
   logic            all_off = 1'b0;
   logic            ev_ready;
   logic [7*NV-1:0] vnote;
   logic [NV-1:0]   vgate;
   logic            steal;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   voice_allocator #(.NUM_VOICES(NV), .STEAL_GAP(SG)) dut (
      .clk_i(clk), .rst_ni(rst_n), .event_valid_i(ev_valid), .event_ready_o(ev_ready),
      .event_on_i(ev_on), .event_note_i(ev_note), .all_off_i(all_off),
      .voice_note_o(vnote), .voice_gate_o(vgate), .steal_pulse_o(steal));

   // Samples taken after edge T+k, where T is the acceptance edge
   logic [NV-1:0]   gate_tr  [1:MAXK];
   logic [7*NV-1:0] note_tr  [1:MAXK];
   logic            steal_tr [1:MAXK];
   logic            ready_tr [1:MAXK];

   // Model: gates, notes, and a least-recently-allocated list (front = oldest)
   bit         m_gate [NV];
   logic [6:0] m_note [NV];
   int         lru [$];

   function automatic logic [NV-1:0] m_gvec();
      logic [NV-1:0] v;
      for (int i = 0; i < NV; i++) v[i] = m_gate[i];
      return v;
   endfunction

   function automatic logic [7*NV-1:0] m_nvec();
      logic [7*NV-1:0] v;
      for (int i = 0; i < NV; i++) v[7*i +: 7] = m_note[i];
      return v;
   endfunction

   task automatic model_reset();
      lru = {};
      for (int i = 0; i < NV; i++) begin
         m_gate[i] = 0;
         m_note[i] = '0;
         lru.push_back(i);
      end
   endtask

   // kind: 0 off, 1 free, 2 retrigger, 3 steal; lat = edges until final state visible
   task automatic model_apply(input bit on, input logic [6:0] note,
                              output int kind, output int tgt, output int lat);
      kind = 0; tgt = 0; lat = 1;
      if (!on) begin
         for (int i = 0; i < NV; i++) if (m_gate[i] && m_note[i] == note) m_gate[i] = 0;
         return;
      end
      kind = -1;
      for (int i = 0; i < NV; i++)
         if (kind < 0 && m_gate[i] && m_note[i] == note) begin kind = 2; tgt = i; end
      if (kind < 0)
         foreach (lru[j]) if (kind < 0 && !m_gate[lru[j]]) begin kind = 1; tgt = lru[j]; end
      if (kind < 0) begin kind = 3; tgt = lru[0]; end
      lat = (kind == 1) ? 2 : 2 + SG;
      m_note[tgt] = note;
      m_gate[tgt] = 1;
      foreach (lru[j]) if (lru[j] == tgt) begin lru.delete(j); break; end
      lru.push_back(tgt);
   endtask

   task automatic do_event(input bit on, input logic [6:0] note, output bit ok);
      int w = 0;
      ok = 1;
      while (ev_ready !== 1'b1) begin
         if (w == 20) begin
            tests++; fails++;
            $display("FAIL ready_timeout: event_ready=%b, required 1 within 20 cycles", ev_ready);
            ok = 0;
            return;
         end
         @(negedge clk); w++;
      end
      ev_valid = 1'b1; ev_on = on; ev_note = note;
      @(negedge clk);
      ev_valid = 1'b0;
      for (int k = 1; k <= MAXK; k++) begin
         @(negedge clk);
         gate_tr[k] = vgate; note_tr[k] = vnote; steal_tr[k] = steal; ready_tr[k] = ev_ready;
      end
   endtask

   task automatic reset_dut();
      @(negedge clk); rst_n = 1'b0;
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      model_reset();
   endtask

   task automatic fill();
      bit ok;
      do_event(1, 7'd60, ok); do_event(1, 7'd62, ok);
      do_event(1, 7'd64, ok); do_event(1, 7'd65, ok);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if ({ev_ready, steal, vgate, vnote} !== '0) begin
         fails++; $display("FAIL reset_outputs: ready=%b steal=%b gate=%b note=%h, required all 0", ev_ready, steal, vgate, vnote);
      end
      rst_n = 1'b1; #1;
      tests++;
      if (ev_ready !== 1'b0) begin fails++; $display("FAIL ready_before_edge: got %b, required 0", ev_ready); end
      @(negedge clk);
      tests++;
      if (ev_ready !== 1'b1) begin fails++; $display("FAIL ready_after_edge: got %b, required 1", ev_ready); end
      tests++;
      if (vgate !== '0 || vnote !== '0) begin fails++; $display("FAIL reset_voices: gate=%b note=%h, required 0", vgate, vnote); end
      model_reset();
   endtask

   task automatic test_fill();
      int notes [4] = '{60, 62, 64, 65};
      logic [7*NV-1:0] en = '0;
      bit ok;
      reset_dut();
      for (int i = 0; i < 4; i++) begin
         do_event(1, 7'(notes[i]), ok);
         en[7*i +: 7] = 7'(notes[i]);
         tests++;
         if (gate_tr[1] !== 4'((1 << i) - 1) || ready_tr[1] !== 1'b0) begin
            fails++; $display("FAIL fill_k1[%0d]: gate=%b ready=%b, required gate=%b ready=0", i, gate_tr[1], ready_tr[1], 4'((1 << i) - 1));
         end
         tests++;
         if (gate_tr[2] !== 4'((1 << (i + 1)) - 1) || note_tr[2] !== en || ready_tr[2] !== 1'b1) begin
            fails++; $display("FAIL fill_k2[%0d]: gate=%b note=%h ready=%b, required gate=%b note=%h ready=1", i, gate_tr[2], note_tr[2], ready_tr[2], 4'((1 << (i + 1)) - 1), en);
         end
      end
   endtask

   task automatic test_steal();
      bit ok;
      do_event(1, 7'd67, ok);
      tests++;
      if (gate_tr[1] !== 4'b1110 || steal_tr[1] !== 1'b1 || steal_tr[2] !== 1'b0) begin
         fails++; $display("FAIL steal_drop: gate=%b steal=%b,%b, required 1110 steal=1,0", gate_tr[1], steal_tr[1], steal_tr[2]);
      end
      tests++;
      if (gate_tr[1+SG] !== 4'b1110 || ready_tr[1+SG] !== 1'b0) begin
         fails++; $display("FAIL steal_gap: gate=%b ready=%b, required 1110 ready=0", gate_tr[1+SG], ready_tr[1+SG]);
      end
      tests++;
      if (gate_tr[2+SG] !== 4'b1111 || note_tr[2+SG][6:0] !== 7'd67 || ready_tr[2+SG] !== 1'b1) begin
         fails++; $display("FAIL steal_regate: gate=%b note0=%0d ready=%b, required 1111 67 1", gate_tr[2+SG], note_tr[2+SG][6:0], ready_tr[2+SG]);
      end
      do_event(1, 7'd69, ok);
      tests++;
      if (gate_tr[1] !== 4'b1101 || steal_tr[1] !== 1'b1 || note_tr[2+SG][13:7] !== 7'd69 || gate_tr[2+SG] !== 4'b1111) begin
         fails++; $display("FAIL steal_next: gate=%b steal=%b note1=%0d, required 1101 1 69", gate_tr[1], steal_tr[1], note_tr[2+SG][13:7]);
      end
   endtask

   task automatic test_noteoff();
      bit ok;
      reset_dut();
      fill();
      do_event(0, 7'd62, ok);
      tests++;
      if (gate_tr[1] !== 4'b1101 || note_tr[1][13:7] !== 7'd62 || ready_tr[1] !== 1'b1) begin
         fails++; $display("FAIL noteoff_62: gate=%b note1=%0d ready=%b, required 1101 62 1", gate_tr[1], note_tr[1][13:7], ready_tr[1]);
      end
      do_event(1, 7'd70, ok);
      tests++;
      if (gate_tr[2] !== 4'b1111 || note_tr[2] !== {7'd65, 7'd64, 7'd70, 7'd60} || steal_tr[1] !== 1'b0) begin
         fails++; $display("FAIL noteon_free: gate=%b note=%h steal=%b, required 1111 %h 0", gate_tr[2], note_tr[2], steal_tr[1], {7'd65, 7'd64, 7'd70, 7'd60});
      end
      do_event(0, 7'd99, ok);
      for (int k = 1; k <= 3; k++) begin
         tests++;
         if (gate_tr[k] !== 4'b1111 || note_tr[k] !== {7'd65, 7'd64, 7'd70, 7'd60}) begin
            fails++; $display("FAIL noteoff_unmatched k=%0d: gate=%b note=%h, required 1111 unchanged", k, gate_tr[k], note_tr[k]);
         end
      end
   endtask

   task automatic test_retrigger();
      bit ok;
      logic any_steal = 1'b0;
      do_event(1, 7'd64, ok);
      for (int k = 1; k <= MAXK; k++) any_steal |= steal_tr[k];
      tests++;
      if (gate_tr[1] !== 4'b1011 || gate_tr[1+SG] !== 4'b1011 || any_steal !== 1'b0) begin
         fails++; $display("FAIL retrig_gap: gate=%b,%b steal=%b, required 1011,1011 steal=0", gate_tr[1], gate_tr[1+SG], any_steal);
      end
      tests++;
      if (gate_tr[2+SG] !== 4'b1111 || note_tr[2+SG] !== {7'd65, 7'd64, 7'd70, 7'd60}) begin
         fails++; $display("FAIL retrig_regate: gate=%b note=%h, required 1111 %h", gate_tr[2+SG], note_tr[2+SG], {7'd65, 7'd64, 7'd70, 7'd60});
      end
   endtask

   task automatic test_all_off();
      bit ok;
      // Voice 0 is oldest at this point, so note-on 80 steals it
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd80;
      @(negedge clk); ev_valid = 1'b0;
      @(negedge clk);
      tests++;
      if (vgate !== 4'b1110 || steal !== 1'b1) begin
         fails++; $display("FAIL alloff_pre: gate=%b steal=%b, required 1110 1", vgate, steal);
      end
      all_off = 1'b1;
      @(negedge clk); all_off = 1'b0;
      tests++;
      if (vgate !== 4'b0000 || ev_ready !== 1'b1) begin
         fails++; $display("FAIL alloff_clear: gate=%b ready=%b, required 0000 1", vgate, ev_ready);
      end
      repeat (4) @(negedge clk);
      tests++;
      if (vgate !== 4'b0000 || vnote[6:0] !== 7'd60 || steal !== 1'b0) begin
         fails++; $display("FAIL alloff_noregate: gate=%b note0=%0d steal=%b, required 0000 60 0", vgate, vnote[6:0], steal);
      end
      do_event(1, 7'd81, ok);
      tests++;
      if (gate_tr[2] !== 4'b0001 || note_tr[2][6:0] !== 7'd81) begin
         fails++; $display("FAIL alloff_ranks: gate=%b note0=%0d, required 0001 81", gate_tr[2], note_tr[2][6:0]);
      end
      // all_off on the acceptance edge discards the event
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd90; all_off = 1'b1;
      @(negedge clk); ev_valid = 1'b0; all_off = 1'b0;
      repeat (3) @(negedge clk);
      tests++;
      if (vgate !== 4'b0000 || vnote[13:7] !== 7'd70 || ev_ready !== 1'b1) begin
         fails++; $display("FAIL alloff_accept: gate=%b note1=%0d ready=%b, required 0000 70 1", vgate, vnote[13:7], ev_ready);
      end
   endtask

   task automatic test_async_reset();
      bit ok;
      do_event(1, 7'd90, ok);
      ev_valid = 1'b1; ev_on = 1'b1; ev_note = 7'd91;
      @(negedge clk); ev_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      tests++;
      if ({ev_ready, steal, vgate, vnote} !== '0) begin
         fails++; $display("FAIL async_reset: ready=%b steal=%b gate=%b note=%h, required all 0", ev_ready, steal, vgate, vnote);
      end
      @(negedge clk); rst_n = 1'b1;
      @(negedge clk);
      tests++;
      if (ev_ready !== 1'b1 || vgate !== '0 || vnote !== '0) begin
         fails++; $display("FAIL async_release: ready=%b gate=%b note=%h, required 1 0 0", ev_ready, vgate, vnote);
      end
      model_reset();
   endtask

   task automatic test_random();
      int pool [8] = '{0, 127, 60, 61, 62, 63, 64, 65};
      int kind, tgt, lat;
      bit on, ok;
      logic [6:0] note;
      reset_dut();
      for (int n = 0; n < 60; n++) begin
         on   = ($urandom_range(0, 9) < 7);
         note = 7'(pool[$urandom_range(0, 7)]);
         model_apply(on, note, kind, tgt, lat);
         do_event(on, note, ok);
         if (!ok) continue;
         tests++;
         if (gate_tr[lat] !== m_gvec() || note_tr[lat] !== m_nvec()) begin
            fails++; $display("FAIL rand_state[%0d]: gate=%b note=%h, required %b %h", n, gate_tr[lat], note_tr[lat], m_gvec(), m_nvec());
         end
         tests++;
         if (ready_tr[lat] !== 1'b1 || (lat > 1 && ready_tr[lat-1] !== 1'b0)) begin
            fails++; $display("FAIL rand_ready[%0d]: ready at k=%0d is %b, required 1 (0 the cycle before)", n, lat, ready_tr[lat]);
         end
         tests++;
         if (steal_tr[1] !== (kind == 3) || steal_tr[2] !== 1'b0) begin
            fails++; $display("FAIL rand_steal[%0d]: steal=%b,%b, required %b,0", n, steal_tr[1], steal_tr[2], kind == 3);
         end
         if (kind >= 2) begin
            tests++;
            if (gate_tr[1][tgt] !== 1'b0 || gate_tr[1+SG][tgt] !== 1'b0) begin
               fails++; $display("FAIL rand_gap[%0d]: voice %0d gate=%b,%b, required 0,0", n, tgt, gate_tr[1][tgt], gate_tr[1+SG][tgt]);
            end
         end
      end
   endtask

   initial begin
      test_reset();
      test_fill();
      test_steal();
      test_noteoff();
      test_retrigger();
      test_all_off();
      test_async_reset();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end

endmodule
